test_st_source: RTL and testbench
=================================

Name: test_st_source

Overview:
- Streaming test-pattern transmitter: drives a valid/ready stream of DATA_WIDTH-bit beats into a sink under test.
- Software or bench issues a start pulse with a beat count. The block emits a deterministic, self-checking pattern, honours backpressure, flags the final beat, and reports completion plus a saturating stall count.
- Sits in front of stream sinks, FIFOs and DMA paths in the same clock domain, for bring-up and throughput measurement.

Parameters:
- DATA_WIDTH, 256, stream beat width in bits; must be a multiple of 32, maximum 8192 (256 lanes).
- COUNT_WIDTH, 16, width of the beat-count request and internal beat index.
- STALL_WIDTH, 32, width of the stall counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a burst; honoured only in IDLE.
- beats  input  COUNT_WIDTH  number of beats to send; sampled on the accepted start.
- st_data  output  DATA_WIDTH  beat payload, registered.
- valid  output  1  payload valid, registered.
- last  output  1  high with the final beat of a burst, registered.
- ready  input  1  sink can accept; a beat transfers on a clk edge where valid && ready.
- busy  output  1  high from the cycle after an accepted start until the cycle done is asserted.
- done  output  1  one-cycle pulse after the final beat transfers, or after a zero-length request.
- stall_cnt  output  STALL_WIDTH  cycles with valid && !ready in the current or most recent burst; saturating.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. st_data=0, valid=0, last=0, busy=0, done=0, stall_cnt=0, beat index=0.
- Reset mid-burst aborts immediately. There is no final last and no done pulse.
- States:
  - IDLE: waits for start.
  - SEND: presents beats.
  - DONE: a one-cycle state that drives done=1.
- IDLE, start=1, beats!=0:
  - Latch beats, clear the beat index and stall_cnt.
  - Next cycle: state=SEND, valid=1, busy=1, st_data = pattern(0), last=(beats==1).
  - Start-to-first-valid latency is 1 cycle.
- IDLE, start=1, beats==0:
  - Go to DONE and clear stall_cnt.
  - valid is never asserted; done=1 the next cycle.
- start while not in IDLE is ignored. It has no effect on beats, index or stall_cnt.
- SEND, valid && !ready: st_data, valid and last hold stable (AXI-stream rule). stall_cnt increments, saturating at all-ones.
- SEND, valid && ready, not the final beat: increment the index and present pattern(index+1) the next cycle with valid still 1. Back-to-back transfers run at 1 beat/cycle.
- SEND, valid && ready && last:
  - Next cycle: valid=0, last=0, st_data holds its value, state=DONE, done=1, busy=0.
  - Following cycle: state=IDLE, done=0.
  - A start in the DONE cycle is ignored.
- valid never drops while a beat is pending, and never depends combinationally on ready.
- Pattern: lane k (st_data[32k+31:32k], k = 0 .. DATA_WIDTH/32-1) = {index[23:0], k[7:0]}.
  - index is zero-extended or truncated to 24 bits.
  - A sink checks beat n by comparing every lane to {n, k}.
- Beat-index wrap: beats max = 2^COUNT_WIDTH-1. The index never exceeds beats-1, so there is no wrap within a burst.
- stall_cnt holds its value after done until the next accepted start or reset.

Test Plan:
- Reset then start with beats=4 and ready held 1 → valid high for 4 consecutive cycles starting 1 cycle after start. Lane0 = 0x00000000, 0x00000100, 0x00000200, 0x00000300; lane7 of beat 2 = 0x00000207. last only on beat 3; done pulses 1 cycle after the last transfer; stall_cnt=0.
- beats=3 with ready toggling 1,0,0,1,0,1 → data, valid and last stable during the low cycles. 3 transfers total; stall_cnt=3 at done.
- beats=0 → valid never asserts, busy stays 0, done pulses exactly 1 cycle after start; stall_cnt=0.
- start pulsed mid-burst (beats=5, second start with beats=2 on beat 2) → still 5 beats, and last on beat index 4.
- rst asserted while valid=1 and ready=0 on beat 1 of 6 → next cycle valid=0, busy=0, done=0, stall_cnt=0. A fresh start with beats=2 then sends indices 0 and 1.
- Hold ready=0 for 2^STALL_WIDTH+10 cycles (with STALL_WIDTH overridden to 4) → stall_cnt saturates at 15 and the pending beat stays unchanged.

Source files
------------

// File: rtl/test_st_source.sv
// -----------------------------------------------------------------------------
// test_st_source
//
// Streaming test-pattern transmitter. A start pulse with a beat count launches a
// burst of deterministic beats on a valid/ready stream. Backpressure is
// honoured, the final beat carries last, and the block pulses done once the
// burst completes. It also reports how many cycles the sink stalled the
// stream, saturating at all-ones.
//
// Beat n carries, in every 32-bit lane k, the word {n[23:0], k[7:0]}. A sink can
// therefore check each beat without keeping any state of its own.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle burst request, honoured only in IDLE
//   beats      in   beat count, sampled on an accepted start (0 = empty burst)
//   st_data    out  beat payload (registered)
//   valid      out  payload valid (registered)
//   last       out  final beat of the burst (registered)
//   ready      in   sink accepts; a beat transfers when valid && ready
//   busy       out  burst in progress
//   done       out  one-cycle completion pulse
//   stall_cnt  out  valid && !ready cycles in the current/last burst
// -----------------------------------------------------------------------------
module test_st_source #(
   parameter int DATA_WIDTH  = 256,
   parameter int COUNT_WIDTH = 16,
   parameter int STALL_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] beats,
   output logic [DATA_WIDTH-1:0]  st_data,
   output logic                   valid,
   output logic                   last,
   input  logic                   ready,
   output logic                   busy,
   output logic                   done,
   output logic [STALL_WIDTH-1:0] stall_cnt
);

   localparam int LANES = DATA_WIDTH / 32;

   localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
   localparam logic [STALL_WIDTH-1:0] STALL_ONE = STALL_WIDTH'(1);
   localparam logic [STALL_WIDTH-1:0] STALL_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 state_q;
   logic [COUNT_WIDTH-1:0] beats_q;
   logic [COUNT_WIDTH-1:0] idx_q;
   logic [COUNT_WIDTH-1:0] idx_d;
   logic [STALL_WIDTH-1:0] stall_q;
   logic [STALL_WIDTH-1:0] stall_d;
   logic [DATA_WIDTH-1:0]  data_q;
   logic                   valid_q;
   logic                   last_q;
   logic                   busy_q;
   logic                   done_q;

   // Payload for beat index idx: every lane is {idx[23:0], lane number}.
   function automatic logic [DATA_WIDTH-1:0] pattern(input logic [COUNT_WIDTH-1:0] idx);
      logic [DATA_WIDTH-1:0] p;
      logic [23:0]           idx24;
      idx24 = 24'(idx);
      p     = '0;
      for (int k = 0; k < LANES; k++) begin
         p[32*k +: 32] = {idx24, 8'(k)};
      end
      return p;
   endfunction

   assign idx_d   = idx_q + CNT_ONE;
   assign stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + STALL_ONE;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         beats_q <= '0;
         idx_q   <= '0;
         stall_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  beats_q <= beats;
                  idx_q   <= '0;
                  stall_q <= '0;
                  if (beats != '0) begin
                     state_q <= S_SEND;
                     data_q  <= pattern('0);
                     valid_q <= 1'b1;
                     last_q  <= (beats == CNT_ONE);
                     busy_q  <= 1'b1;
                  end else begin
                     // Empty burst: skip straight to the completion pulse.
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end

            S_SEND: begin
               if (valid_q && ready) begin
                  if (last_q) begin
                     // Payload is left as-is; only the qualifiers drop.
                     state_q <= S_DONE;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q  <= idx_d;
                     data_q <= pattern(idx_d);
                     last_q <= (idx_d == beats_q - CNT_ONE);
                  end
               end else if (valid_q) begin
                  // Sink stalled: beat holds, only the stall counter moves.
                  stall_q <= stall_d;
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end

            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
               last_q  <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign st_data   = data_q;
   assign valid     = valid_q;
   assign last      = last_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_test_st_source.sv
// -----------------------------------------------------------------------------
// tb_test_st_source
//
// Directed bench for test_st_source. The stall counter is narrowed to 4 bits
// so that saturation is reachable. Inputs change 1 ns after a rising edge, and
// outputs are read at that same point.
// -----------------------------------------------------------------------------
module tb_test_st_source;

   localparam int DW = 256;
   localparam int CW = 16;
   localparam int SW = 4;

   logic          clk;
   logic          rst;
   logic          start;
   logic [CW-1:0] beats;
   logic [DW-1:0] st_data;
   logic          valid;
   logic          last;
   logic          ready;
   logic          busy;
   logic          done;
   logic [SW-1:0] stall_cnt;

   int ncmp;
   int nerr;

   test_st_source #(
      .DATA_WIDTH (DW),
      .COUNT_WIDTH(CW),
      .STALL_WIDTH(SW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .beats    (beats),
      .st_data  (st_data),
      .valid    (valid),
      .last     (last),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] lane(input int k);
      return st_data[32*k +: 32];
   endfunction

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; beats = '0; ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      ncmp++; if (valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b exp 0", valid); end
      ncmp++; if (last !== 1'b0) begin nerr++; $display("FAIL reset_last got %b exp 0", last); end
      ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b exp 0", busy); end
      ncmp++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b exp 0", done); end
      ncmp++; if (stall_cnt !== 4'd0) begin nerr++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
      ncmp++; if (st_data !== '0) begin nerr++; $display("FAIL reset_data got %h exp 0", st_data); end
   endtask

   task automatic test_basic();
      logic [31:0] exp0 [4];
      exp0[0] = 32'h0000_0000; exp0[1] = 32'h0000_0100;
      exp0[2] = 32'h0000_0200; exp0[3] = 32'h0000_0300;
      ready = 1'b1; start = 1'b1; beats = 16'd4;
      tick();
      start = 1'b0;
      for (int n = 0; n < 4; n++) begin
         ncmp++; if (valid !== 1'b1) begin nerr++; $display("FAIL basic_valid n=%0d got %b exp 1", n, valid); end
         ncmp++; if (busy !== 1'b1) begin nerr++; $display("FAIL basic_busy n=%0d got %b exp 1", n, busy); end
         ncmp++; if (lane(0) !== exp0[n]) begin nerr++; $display("FAIL basic_lane0 n=%0d got %h exp %h", n, lane(0), exp0[n]); end
         ncmp++; if (last !== (n == 3)) begin nerr++; $display("FAIL basic_last n=%0d got %b exp %b", n, last, (n == 3)); end
         if (n == 2) begin
            ncmp++; if (lane(7) !== 32'h0000_0207) begin nerr++; $display("FAIL basic_lane7 got %h exp 00000207", lane(7)); end
         end
         tick();
      end
      ncmp++; if (valid !== 1'b0) begin nerr++; $display("FAIL basic_end_valid got %b exp 0", valid); end
      ncmp++; if (last !== 1'b0) begin nerr++; $display("FAIL basic_end_last got %b exp 0", last); end
      ncmp++; if (done !== 1'b1) begin nerr++; $display("FAIL basic_done got %b exp 1", done); end
      ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL basic_end_busy got %b exp 0", busy); end
      ncmp++; if (lane(0) !== 32'h0000_0300) begin nerr++; $display("FAIL basic_hold got %h exp 00000300", lane(0)); end
      ncmp++; if (stall_cnt !== 4'd0) begin nerr++; $display("FAIL basic_stall got %0d exp 0", stall_cnt); end
      tick();
      ncmp++; if (done !== 1'b0) begin nerr++; $display("FAIL basic_done_clr got %b exp 0", done); end
   endtask

   task automatic test_backpressure();
      logic [5:0]    seq;
      logic [DW-1:0] prev;
      logic          prev_last;
      int            exp_idx;
      int            xfers;
      seq = 6'b101001;   // ready per cycle, bit 0 first: 1,0,0,1,0,1
      exp_idx = 0; xfers = 0;
      ready = 1'b0; start = 1'b1; beats = 16'd3;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         ncmp++; if (valid !== 1'b1) begin nerr++; $display("FAIL bp_valid i=%0d got %b exp 1", i, valid); end
         ncmp++; if (lane(0) !== {exp_idx[23:0], 8'h00}) begin nerr++; $display("FAIL bp_lane0 i=%0d got %h exp %h", i, lane(0), {exp_idx[23:0], 8'h00}); end
         ncmp++; if (last !== (exp_idx == 2)) begin nerr++; $display("FAIL bp_last i=%0d got %b exp %b", i, last, (exp_idx == 2)); end
         prev = st_data; prev_last = last;
         ready = seq[i];
         tick();
         if (seq[i]) begin
            exp_idx++; xfers++;
         end else begin
            ncmp++; if (st_data !== prev || last !== prev_last || valid !== 1'b1) begin
               nerr++; $display("FAIL bp_hold i=%0d got %h/%b/%b exp %h/%b/1", i, st_data, last, valid, prev, prev_last);
            end
         end
      end
      ncmp++; if (xfers !== 3) begin nerr++; $display("FAIL bp_xfers got %0d exp 3", xfers); end
      ncmp++; if (done !== 1'b1) begin nerr++; $display("FAIL bp_done got %b exp 1", done); end
      ncmp++; if (valid !== 1'b0) begin nerr++; $display("FAIL bp_end_valid got %b exp 0", valid); end
      ncmp++; if (stall_cnt !== 4'd3) begin nerr++; $display("FAIL bp_stall got %0d exp 3", stall_cnt); end
      ready = 1'b1;
      tick();
      ncmp++; if (stall_cnt !== 4'd3) begin nerr++; $display("FAIL bp_stall_hold got %0d exp 3", stall_cnt); end
      ncmp++; if (done !== 1'b0) begin nerr++; $display("FAIL bp_done_clr got %b exp 0", done); end
   endtask

   task automatic test_zero();
      start = 1'b1; beats = 16'd0;
      tick();
      start = 1'b0;
      ncmp++; if (valid !== 1'b0) begin nerr++; $display("FAIL zero_valid got %b exp 0", valid); end
      ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL zero_busy got %b exp 0", busy); end
      ncmp++; if (done !== 1'b1) begin nerr++; $display("FAIL zero_done got %b exp 1", done); end
      ncmp++; if (stall_cnt !== 4'd0) begin nerr++; $display("FAIL zero_stall got %0d exp 0", stall_cnt); end
      tick();
      ncmp++; if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
         nerr++; $display("FAIL zero_after got done=%b valid=%b busy=%b exp 0/0/0", done, valid, busy);
      end
   endtask

   task automatic test_midstart();
      ready = 1'b1; start = 1'b1; beats = 16'd5;
      tick();
      start = 1'b0;
      for (int n = 0; n < 5; n++) begin
         ncmp++; if (valid !== 1'b1 || lane(0) !== {n[23:0], 8'h00}) begin
            nerr++; $display("FAIL mid_beat n=%0d got %b/%h exp 1/%h", n, valid, lane(0), {n[23:0], 8'h00});
         end
         ncmp++; if (last !== (n == 4)) begin nerr++; $display("FAIL mid_last n=%0d got %b exp %b", n, last, (n == 4)); end
         if (n == 2) begin
            start = 1'b1; beats = 16'd2;
         end
         tick();
         start = 1'b0;
      end
      ncmp++; if (done !== 1'b1 || valid !== 1'b0) begin
         nerr++; $display("FAIL mid_done got done=%b valid=%b exp 1/0", done, valid);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      ready = 1'b1; start = 1'b1; beats = 16'd6;
      tick();
      start = 1'b0;
      tick();
      ready = 1'b0;
      tick();
      ncmp++; if (valid !== 1'b1 || lane(0) !== 32'h0000_0100) begin
         nerr++; $display("FAIL rm_pre got %b/%h exp 1/00000100", valid, lane(0));
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ncmp++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || stall_cnt !== 4'd0) begin
         nerr++; $display("FAIL rm_after got v=%b b=%b d=%b s=%0d exp 0/0/0/0", valid, busy, done, stall_cnt);
      end
      tick();
      ncmp++; if (done !== 1'b0 || valid !== 1'b0) begin
         nerr++; $display("FAIL rm_quiet got d=%b v=%b exp 0/0", done, valid);
      end
      ready = 1'b1; start = 1'b1; beats = 16'd2;
      tick();
      start = 1'b0;
      ncmp++; if (valid !== 1'b1 || lane(0) !== 32'h0 || last !== 1'b0) begin
         nerr++; $display("FAIL rm_beat0 got %b/%h/%b exp 1/00000000/0", valid, lane(0), last);
      end
      tick();
      ncmp++; if (valid !== 1'b1 || lane(0) !== 32'h0000_0100 || last !== 1'b1) begin
         nerr++; $display("FAIL rm_beat1 got %b/%h/%b exp 1/00000100/1", valid, lane(0), last);
      end
      tick();
      ncmp++; if (done !== 1'b1) begin nerr++; $display("FAIL rm_done got %b exp 1", done); end
      tick();
   endtask

   task automatic test_saturate();
      logic [DW-1:0] held;
      ready = 1'b0; start = 1'b1; beats = 16'd3;
      tick();
      start = 1'b0;
      held = st_data;
      for (int i = 0; i < (1 << SW) + 10; i++) begin
         tick();
         ncmp++; if (valid !== 1'b1 || st_data !== held) begin
            nerr++; $display("FAIL sat_hold i=%0d got v=%b lane0=%h exp 1/00000000", i, valid, lane(0));
         end
      end
      ncmp++; if (stall_cnt !== 4'd15) begin nerr++; $display("FAIL sat_cnt got %0d exp 15", stall_cnt); end
      ncmp++; if (lane(0) !== 32'h0 || lane(7) !== 32'h7) begin
         nerr++; $display("FAIL sat_data got %h/%h exp 00000000/00000007", lane(0), lane(7));
      end
      ready = 1'b1;
      tick(); tick(); tick();
      ncmp++; if (done !== 1'b1 || stall_cnt !== 4'd15) begin
         nerr++; $display("FAIL sat_done got d=%b s=%0d exp 1/15", done, stall_cnt);
      end
      tick();
   endtask

   initial begin
      ncmp = 0; nerr = 0;
      rst = 1'b1; start = 1'b0; beats = '0; ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_zero();
      test_midstart();
      test_reset_mid();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
